// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
//   Shared types and constants for the unified-memory port arbiter.
//   - arb_state_e : arbiter FSM states (IDLE / FETCH / DATA)
//   - req_sel_e   : which requester wins a grant slot
//   - DEFAULT_WAIT: default access length for fetches and data with wait==0
//   - access_len(): resolves the decoder-supplied wait field to a length
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_FETCH = 2'd1,
    ARB_DATA  = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_IF   = 2'd1,
    SEL_DM   = 2'd2
  } req_sel_e;

  localparam int DEFAULT_WAIT = 2;
  localparam int CNT_W        = 4;

  // A zero wait field from decode means "use the default access length".
  function automatic logic [CNT_W-1:0] access_len(input logic [CNT_W-1:0] dm_wait,
                                                  input logic [CNT_W-1:0] dflt);
    return (dm_wait == '0) ? dflt : dm_wait;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles the fetch port, the data port and the memory-side bus of the
//   arbiter. Signal names keep the i_/o_ direction as seen by the arbiter.
//   modport slave  : the arbiter (consumes i_*, drives o_*)
//   modport master : the surrounding pipeline + memory (drives i_*)
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  // instruction fetch port
  logic              i_if_req;
  logic [ADDR_W-1:0] i_if_addr;
  logic              o_if_ack;
  logic [DATA_W-1:0] o_if_rdata;
  // data (LDR/STR) port
  logic              i_dm_req;
  logic              i_dm_we;
  logic [3:0]        i_dm_wait;
  logic [ADDR_W-1:0] i_dm_addr;
  logic [DATA_W-1:0] i_dm_wdata;
  logic              o_dm_ack;
  logic [DATA_W-1:0] o_dm_rdata;
  // pipeline stall
  logic              o_stall;
  // memory bus
  logic              o_mem_en;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata;

  modport slave (
    input  i_if_req, i_if_addr, i_dm_req, i_dm_we, i_dm_wait, i_dm_addr,
           i_dm_wdata, i_mem_rdata,
    output o_if_ack, o_if_rdata, o_dm_ack, o_dm_rdata, o_stall,
           o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
  );

  modport master (
    output i_if_req, i_if_addr, i_dm_req, i_dm_we, i_dm_wait, i_dm_addr,
           i_dm_wdata, i_mem_rdata,
    input  o_if_ack, o_if_rdata, o_dm_ack, o_dm_rdata, o_stall,
           o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_wait_cnt.sv
// ---------------------------------------------------------------------------
// mem_arb_wait_cnt
//   Access-length down-counter. Loaded with N at grant, counts down each
//   cycle and stops at zero (no wrap). last is high while the count is 1,
//   i.e. on the final cycle of the access.
//   clk      : clock
//   rst      : asynchronous active-low reset
//   load     : load load_val this edge (takes priority over counting)
//   load_val : access length N (1..15)
//   last     : final cycle of the current access
// ---------------------------------------------------------------------------
module mem_arb_wait_cnt
  import mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares the single-port unified memory between instruction fetch and the
//   LDR/STR data path. One requester is granted at a time; the memory bus is
//   latched at grant and held for N cycles, the ack pulses on the last cycle
//   and read data is captured at the edge that closes that cycle. A new
//   grant is taken on that same edge, so back-to-back accesses have no gap.
//   Ports (all inside bus, modport slave, except clk/rst):
//     clk, rst                 clock, asynchronous active-low reset
//     i_if_req/addr, o_if_ack/rdata            fetch port
//     i_dm_req/we/wait/addr/wdata, o_dm_ack/rdata  data port
//     o_stall                  combinational pipeline stall
//     o_mem_en/we/addr/wdata, i_mem_rdata      memory bus
//   Optional feature: define MEM_ARB_STARVE_GUARD_EN to force a fetch grant
//   after STARVE_LIMIT consecutive data grants made while a fetch waits.
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = DEFAULT_WAIT
`ifdef MEM_ARB_STARVE_GUARD_EN
  , parameter int STARVE_LIMIT = 4
`endif
) (
  input  logic             clk,
  input  logic             rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [1:0]       ST_IDLE  = ARB_IDLE;
  localparam logic [1:0]       ST_FETCH = ARB_FETCH;
  localparam logic [1:0]       ST_DATA  = ARB_DATA;
  localparam logic [CNT_W-1:0] WAIT_N   = CNT_W'(WAIT_CYCLES);

  logic [1:0]        state_q, state_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_last;
  logic              grant_slot;
  logic              force_if;
  logic              if_ack, dm_ack;
  req_sel_e          sel;

  mem_arb_wait_cnt u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .last     (cnt_last)
  );

  // Grants are only taken when idle or on the closing cycle of an access.
  assign grant_slot = (state_q == ST_IDLE) || cnt_last;

`ifdef MEM_ARB_STARVE_GUARD_EN
  // Consecutive data grants made while a fetch was waiting.
  logic [2:0] starve_q, starve_d;

  assign force_if = bus.i_if_req && (starve_q >= 3'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (!bus.i_if_req) begin
      starve_d = '0;
    end else if (grant_slot && (sel == SEL_DM)) begin
      starve_d = (starve_q == 3'd7) ? starve_q : starve_q + 3'd1;
    end else if (grant_slot && (sel == SEL_IF)) begin
      starve_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  // Data wins unless the starvation guard has tripped.
  always_comb begin
    sel = SEL_NONE;
    if (bus.i_dm_req && !force_if) begin
      sel = SEL_DM;
    end else if (bus.i_if_req) begin
      sel = SEL_IF;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    cnt_load    = 1'b0;
    cnt_val     = WAIT_N;

    if (grant_slot) begin
      // Closing an access: capture read data (stores leave dm rdata alone).
      if (state_q == ST_FETCH) begin
        if_rdata_d = bus.i_mem_rdata;
      end
      if ((state_q == ST_DATA) && !mem_we_q) begin
        dm_rdata_d = bus.i_mem_rdata;
      end

      case (sel)
        SEL_DM: begin
          state_d     = ST_DATA;
          mem_en_d    = 1'b1;
          mem_we_d    = bus.i_dm_we;
          mem_addr_d  = bus.i_dm_addr;
          mem_wdata_d = bus.i_dm_wdata;
          cnt_load    = 1'b1;
          cnt_val     = access_len(bus.i_dm_wait, WAIT_N);
        end
        SEL_IF: begin
          state_d     = ST_FETCH;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.i_if_addr;
          mem_wdata_d = '0;
          cnt_load    = 1'b1;
          cnt_val     = WAIT_N;
        end
        default: begin
          state_d     = ST_IDLE;
          mem_en_d    = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign if_ack = (state_q == ST_FETCH) && cnt_last;
  assign dm_ack = (state_q == ST_DATA) && cnt_last;

  assign bus.o_if_ack    = if_ack;
  assign bus.o_dm_ack    = dm_ack;
  assign bus.o_if_rdata  = if_rdata_q;
  assign bus.o_dm_rdata  = dm_rdata_q;
  assign bus.o_mem_en    = mem_en_q;
  assign bus.o_mem_we    = mem_we_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_wdata = mem_wdata_q;
  // Held low in reset so every output is quiet while rst is asserted.
  assign bus.o_stall     = rst && ((bus.i_dm_req && !dm_ack) || (bus.i_if_req && !if_ack));

endmodule
